// File: rtl/led_blink_multi.sv
// led_blink_multi: NCH-channel LED driver with OFF / ON / BLINK / BLINK_PWM modes.
// A shared prescaler produces the blink tick and a shared free-running counter
// produces the PWM frame. Each channel is configured through a one-cycle write port.
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   CFG_WE    config write strobe
//   CFG_CH    target channel (writes to CFG_CH >= NCH are dropped)
//   CFG_MODE  0=OFF 1=ON 2=BLINK 3=BLINK_PWM
//   CFG_DUTY  PWM on-count per frame
//   CFG_HALF  blink half-period in ticks (0 behaves as 1)
//   LED       registered LED outputs
//   TICK      registered one-cycle pulse every PRESCALE cycles
//   TICK_CNT  ticks since reset, wraps
module led_blink_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned HALF_W   = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 CFG_WE,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CFG_CH,
  input  logic [1:0]                           CFG_MODE,
  input  logic [PWM_W-1:0]                     CFG_DUTY,
  input  logic [HALF_W-1:0]                    CFG_HALF,
  output logic [NCH-1:0]                       LED,
  output logic                                 TICK,
  output logic [CNT_W-1:0]                     TICK_CNT
);

  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_PWM   = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e             mode;
    logic [PWM_W-1:0]  duty;
    logic [HALF_W-1:0] half;
    logic [HALF_W-1:0] pcnt;
    logic              phase;
  } chan_t;

  logic [PRE_W-1:0]  pre_q;
  logic [PWM_W-1:0]  pwm_q;
  logic              tick_en_c;
  chan_t             chan_q   [NCH];
  logic [HALF_W-1:0] last_cnt [NCH];
  logic [NCH-1:0]    wr_sel;
  logic [NCH-1:0]    led_d;

  assign tick_en_c = (pre_q == PRE_W'(PRESCALE - 1));

  // Shared time base: prescaler, tick pulse/counter and PWM frame counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q    <= '0;
      pwm_q    <= '0;
      TICK     <= 1'b0;
      TICK_CNT <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      if (tick_en_c) begin
        pre_q    <= '0;
        TICK     <= 1'b1;
        TICK_CNT <= TICK_CNT + CNT_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
        TICK  <= 1'b0;
      end
    end
  end

  // Write decode and per-channel terminal count (half of 0 behaves as 1)
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_sel[i]   = CFG_WE && (CH_W'(i) == CFG_CH);
      last_cnt[i] = (chan_q[i].half == '0) ? '0 : chan_q[i].half - HALF_W'(1);
    end
  end

  // Channel state; a write wins over a tick arriving in the same cycle
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RST) begin
        chan_q[i].mode  <= M_OFF;
        chan_q[i].duty  <= '0;
        chan_q[i].half  <= HALF_W'(1);
        chan_q[i].pcnt  <= '0;
        chan_q[i].phase <= 1'b0;
      end else if (wr_sel[i]) begin
        chan_q[i].mode  <= mode_e'(CFG_MODE);
        chan_q[i].duty  <= CFG_DUTY;
        chan_q[i].half  <= CFG_HALF;
        chan_q[i].pcnt  <= '0;
        chan_q[i].phase <= 1'b1;
      end else if (tick_en_c) begin
        if (chan_q[i].pcnt == last_cnt[i]) begin
          chan_q[i].pcnt  <= '0;
          chan_q[i].phase <= ~chan_q[i].phase;
        end else begin
          chan_q[i].pcnt <= chan_q[i].pcnt + HALF_W'(1);
        end
      end
    end
  end

  // Next LED value from the registered channel state
  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (chan_q[i].mode)
        M_OFF:   led_d[i] = 1'b0;
        M_ON:    led_d[i] = 1'b1;
        M_BLINK: led_d[i] = chan_q[i].phase;
        M_PWM:   led_d[i] = chan_q[i].phase && (pwm_q < chan_q[i].duty);
        default: led_d[i] = 1'b0;
      endcase
    end
  end

  // LED outputs come straight from flops
  always_ff @(posedge CLK) begin
    if (RST) LED <= '0;
    else     LED <= led_d;
  end

endmodule
